uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among N_REQ byte sources. Selects requesters round-robin and

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// Purely declarative: no logic, no latency.
// No flow control of its own; it only sizes the arbiter's ports and counters.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    // Grant index width; a single requester still needs a 1-bit id.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wait counter width able to hold values up to t.
    function automatic int cntw(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among pending requests, starting just after the last grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = idw(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_last,
    output logic             o_grant_vld,
    output logic [IDW-1:0]   o_grant_id
);

    int w_idx;

    // Walk the offsets from farthest to nearest so the nearest pending request wins.
    always_comb begin
        o_grant_vld = 1'b0;
        o_grant_id  = '0;
        w_idx       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_last) + 1 + k) % N_REQ;
            if (i_req[w_idx]) begin
                o_grant_vld = 1'b1;
                o_grant_id  = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources; optional UART_ARB_URGENT_EN gives requester 0 strict priority.
// Latency: 1 clk from req_valid to req_ready/tx_start; frame ends 1 clk after tx_busy falls (done).
// Backpressure: requesters are held off until the current frame completes or times out.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 8,
    parameter int TIMEOUT = 1023,
    localparam int IDW    = idw(N_REQ)
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*D_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [D_WIDTH-1:0]       tx_data,
    input  logic                     tx_busy,
    output logic [IDW-1:0]           grant_id,
    output logic                     done,
    output logic                     timeout_err,
    output logic                     active
);

    localparam int           CW        = cntw(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(N_REQ - 1);

    state_t             r_state;
    logic [IDW-1:0]     r_last;
    logic [CW-1:0]      r_cnt;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_tx_start;
    logic [D_WIDTH-1:0] r_tx_data;
    logic [IDW-1:0]     r_grant_id;
    logic               r_done;
    logic               r_timeout_err;
    logic               r_active;

    state_t             w_state_nxt;
    logic [IDW-1:0]     w_last_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [N_REQ-1:0]   w_ready_nxt;
    logic               w_start_nxt;
    logic [D_WIDTH-1:0] w_data_nxt;
    logic [IDW-1:0]     w_gid_nxt;
    logic               w_done_nxt;
    logic               w_to_nxt;

    logic               w_rr_vld;
    logic [IDW-1:0]     w_rr_id;
    logic               w_gnt_vld;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_gnt_moves_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .i_req       (req_valid),
        .i_last      (r_last),
        .o_grant_vld (w_rr_vld),
        .o_grant_id  (w_rr_id)
    );

    // Final winner: urgent requester 0 overrides the rotation without advancing the pointer.
    always_comb begin
        w_gnt_vld       = w_rr_vld;
        w_gnt_id        = w_rr_id;
        w_gnt_moves_ptr = 1'b1;
`ifdef UART_ARB_URGENT_EN
        if (req_valid[0]) begin
            w_gnt_id        = '0;
            w_gnt_moves_ptr = 1'b0;
        end
`endif
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_data_nxt  = r_tx_data;
        w_gid_nxt   = r_grant_id;
        w_done_nxt  = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt           = LAUNCH;
                    w_data_nxt            = req_data[int'(w_gnt_id) * D_WIDTH +: D_WIDTH];
                    w_gid_nxt             = w_gnt_id;
                    w_ready_nxt[w_gnt_id] = 1'b1;
                    w_start_nxt           = 1'b1;
                    w_cnt_nxt             = '0;
                    if (w_gnt_moves_ptr) begin
                        w_last_nxt = w_gnt_id;
                    end
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_start_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state       <= IDLE;
            r_last        <= LAST_INIT;
            r_cnt         <= '0;
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            r_req_ready   <= w_ready_nxt;
            r_tx_start    <= w_start_nxt;
            r_tx_data     <= w_data_nxt;
            r_grant_id    <= w_gid_nxt;
            r_done        <= w_done_nxt;
            r_timeout_err <= w_to_nxt;
            r_active      <= (w_state_nxt != IDLE);
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign active      = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a long-timeout instance and a TIMEOUT=16 instance share stimulus.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Define UART_ARB_URGENT_EN to exercise the strict-priority variant of the priority scenario.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        arst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        tx_busy;

    logic [3:0]  req_ready,   req_ready_t;
    logic        tx_start,    tx_start_t;
    logic [7:0]  tx_data,     tx_data_t;
    logic [1:0]  grant_id,    grant_id_t;
    logic        done,        done_t;
    logic        timeout_err, timeout_err_t;
    logic        active,      active_t;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(4), .D_WIDTH(8), .TIMEOUT(64)) u_dut (
        .clk(clk), .arst(arst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .done(done), .timeout_err(timeout_err), .active(active)
    );

    uart_tx_arbiter #(.N_REQ(4), .D_WIDTH(8), .TIMEOUT(16)) u_to (
        .clk(clk), .arst(arst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_t), .tx_start(tx_start_t), .tx_data(tx_data_t), .tx_busy(tx_busy),
        .grant_id(grant_id_t), .done(done_t), .timeout_err(timeout_err_t), .active(active_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst      = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'h0;
        tx_busy   = 1'b0;
        repeat (2) tick();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst      = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'h0;
        tx_busy   = 1'b0;
        repeat (2) tick();
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if ({done, timeout_err, active} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {done, timeout_err, active}); end
        arst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        checks++; if ({tx_start, active} !== 2'b11) begin errors++; $display("FAIL single_start: got %b want 11", {tx_start, active}); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", tx_data); end
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        tick();
        checks++; if ({req_ready, tx_start} !== 5'b00001) begin errors++; $display("FAIL single_hold: got %b want 00001", {req_ready, tx_start}); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_held: got %h want a5", tx_data); end
        tx_busy = 1'b1;
        tick();
        checks++; if ({tx_start, active, done} !== 3'b010) begin errors++; $display("FAIL single_busy: got %b want 010", {tx_start, active, done}); end
        tick();
        tx_busy = 1'b0;
        tick();
        checks++; if ({done, grant_id, active} !== 4'b1000) begin errors++; $display("FAIL single_done: got %b want 1000", {done, grant_id, active}); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_id;
        logic [3:0] exp_rdy;
        logic [7:0] exp_d;
        do_reset();
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_id  = 2'(f % 4);
            exp_rdy = 4'b0001 << exp_id;
            exp_d   = 8'h10 + 8'(exp_id);
            n = 0;
            while (req_ready === 4'b0 && n < 50) begin tick(); n++; end
            checks++; if (n >= 50) begin errors++; $display("FAIL rr_wait_grant: frame %0d got no grant want grant", f); end
            checks++; if ({req_ready, grant_id} !== {exp_rdy, exp_id}) begin errors++; $display("FAIL rr_order: frame %0d got %b/%0d want %b/%0d", f, req_ready, grant_id, exp_rdy, exp_id); end
            checks++; if (tx_data !== exp_d) begin errors++; $display("FAIL rr_data: frame %0d got %h want %h", f, tx_data, exp_d); end
            tx_busy = 1'b1;
            repeat (20) tick();
            tx_busy = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 10) begin tick(); n++; end
            checks++; if (done !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL rr_done: frame %0d got done=%b id=%0d want done=1 id=%0d", f, done, grant_id, exp_id); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rr_done_once: frame %0d got %b want 0", f, done); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        int n;
        bit saw_done;
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_5CA5;
        tick();
        req_valid = 4'b0000;
        n = 0;
        saw_done = 1'b0;
        while (tx_start_t === 1'b1 && n < 40) begin
            n++;
            tick();
            if (done_t === 1'b1) saw_done = 1'b1;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL to_launch_cycles: got %0d want 16", n); end
        checks++; if ({timeout_err_t, tx_start_t, active_t} !== 3'b100) begin errors++; $display("FAIL to_pulse: got %b want 100", {timeout_err_t, tx_start_t, active_t}); end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL to_no_done: got %b want 0", saw_done); end
        req_valid = 4'b0010;
        tick();
        checks++; if (timeout_err_t !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", timeout_err_t); end
        checks++; if ({req_ready_t, grant_id_t, tx_data_t} !== {4'b0010, 2'd1, 8'h5C}) begin errors++; $display("FAIL to_next_grant: got %b/%0d/%h want 0010/1/5c", req_ready_t, grant_id_t, tx_data_t); end
        req_valid = 4'b0000;
        tx_busy   = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        checks++; if ({done_t, grant_id_t} !== 3'b101) begin errors++; $display("FAIL to_next_done: got %b want 101", {done_t, grant_id_t}); end
    endtask

    task automatic test_arst_mid_frame();
        bit saw_done;
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        tick();
        req_valid = 4'b0000;
        tx_busy   = 1'b1;
        tick();
        tick();
        checks++; if ({active, grant_id} !== 3'b110) begin errors++; $display("FAIL arst_pre: got %b want 110", {active, grant_id}); end
        arst = 1'b1;
        #1;
        checks++; if ({req_ready, tx_start, tx_data, grant_id, done, timeout_err, active} !== 18'h0) begin errors++; $display("FAIL arst_async: got %h want 0", {req_ready, tx_start, tx_data, grant_id, done, timeout_err, active}); end
        #2;
        arst      = 1'b0;
        tx_busy   = 1'b0;
        req_valid = 4'b1111;
        saw_done  = 1'b0;
        tick();
        if (done === 1'b1) saw_done = 1'b1;
        checks++; if ({req_ready, grant_id} !== {4'b0001, 2'd0}) begin errors++; $display("FAIL arst_next_grant: got %b/%0d want 0001/0", req_ready, grant_id); end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL arst_no_done: got %b want 0", saw_done); end
        req_valid = 4'b0000;
    endtask

    task automatic test_priority();
        logic [1:0] exp2;
        logic [1:0] exp3;
`ifdef UART_ARB_URGENT_EN
        exp2 = 2'd0;
        exp3 = 2'd2;
`else
        exp2 = 2'd2;
        exp3 = 2'd3;
`endif
        do_reset();
        req_data  = 32'hD3D2_D1D0;
        req_valid = 4'b1110;
        tick();
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL prio_first: got %0d want 1", grant_id); end
        req_valid = 4'b1101;
        tx_busy   = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        tick();
        checks++; if ({req_ready, grant_id} !== {4'b0001 << exp2, exp2}) begin errors++; $display("FAIL prio_second: got %b/%0d want %0d", req_ready, grant_id, exp2); end
        req_valid = 4'b1100;
        tx_busy   = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        tick();
        checks++; if ({req_ready, grant_id} !== {4'b0001 << exp3, exp3}) begin errors++; $display("FAIL prio_third: got %b/%0d want %0d", req_ready, grant_id, exp3); end
        req_valid = 4'b0000;
    endtask

    task automatic test_busy_on_entry();
        int starts;
        do_reset();
        tx_busy   = 1'b1;
        req_valid = 4'b0001;
        req_data  = 32'h0000_0042;
        tick();
        req_valid = 4'b0000;
        starts = (tx_start === 1'b1) ? 1 : 0;
        repeat (4) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        checks++; if (starts !== 1) begin errors++; $display("FAIL busy_entry_start: got %0d cycles want 1", starts); end
        checks++; if ({active, done} !== 2'b10) begin errors++; $display("FAIL busy_entry_state: got %b want 10", {active, done}); end
        tx_busy = 1'b0;
        tick();
        checks++; if ({done, active} !== 2'b10) begin errors++; $display("FAIL busy_entry_done: got %b want 10", {done, active}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_arst_mid_frame();
        test_priority();
        test_busy_on_entry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
